// File: rtl/demux4_reg.sv
// demux4_reg: registered 1-to-4 demultiplexer with a one-entry holding
// register per lane and valid/ready handshakes on both sides.
// Optional feature: define DEMUX4_BROADCAST_EN to add the bcast port, which
// loads the same word into all four lanes in one transfer.
module demux4_reg #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_select,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [2:0]         occupancy
`ifdef DEMUX4_BROADCAST_EN
    ,
    input  logic               bcast
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      lane_state [4];
    lane_state_t      lane_next  [4];
    logic [WIDTH-1:0] lane_data  [4];
    logic [3:0]       lane_free;
    logic [3:0]       lane_load;
    logic [3:0]       valid_next;
    logic             bcast_sel;
    logic             in_xfer;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

`ifdef DEMUX4_BROADCAST_EN
    assign bcast_sel = bcast;
`else
    assign bcast_sel = 1'b0;
`endif

    // Handshake decode: a lane is free when empty or being drained this cycle.
    // in_ready never looks at in_valid, so the source may use it to decide.
    always_comb begin
        lane_free = '0;
        lane_load = '0;
        in_ready  = 1'b0;
        in_xfer   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            lane_free[n] = (lane_state[n] == EMPTY) || out_ready[n];
        end
        if (bcast_sel) begin
            in_ready = &lane_free;
        end else begin
            in_ready = lane_free[in_select];
        end
        in_xfer = in_valid && in_ready;
        for (int n = 0; n < 4; n++) begin
            lane_load[n] = in_xfer && (bcast_sel || (in_select == 2'(n)));
        end
    end

    // Per-lane next state: refill wins over drain, so a lane drained and
    // refilled on the same edge stays FULL with no bubble.
    always_comb begin
        valid_next = '0;
        for (int n = 0; n < 4; n++) begin
            lane_next[n] = lane_state[n];
            case (lane_state[n])
                EMPTY: if (lane_load[n]) lane_next[n] = FULL;
                FULL: begin
                    if (lane_load[n])      lane_next[n] = FULL;
                    else if (out_ready[n]) lane_next[n] = EMPTY;
                end
                default: lane_next[n] = EMPTY;
            endcase
            valid_next[n] = (lane_next[n] == FULL);
        end
    end

    // Lane state and occupancy registers; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) lane_state[n] <= EMPTY;
            occupancy <= '0;
        end else begin
            for (int n = 0; n < 4; n++) lane_state[n] <= lane_next[n];
            occupancy <= popcount4(valid_next);
        end
    end

    // Lane data registers: load only on transfer, otherwise hold last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) lane_data[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (lane_load[n]) lane_data[n] <= in_data;
            end
        end
    end

    // Output packing: lane n occupies bits [n*WIDTH +: WIDTH].
    always_comb begin
        out_data  = '0;
        out_valid = '0;
        for (int n = 0; n < 4; n++) begin
            out_data[n*WIDTH +: WIDTH] = lane_data[n];
            out_valid[n]               = (lane_state[n] == FULL);
        end
    end

endmodule

// File: tb/tb_demux4_reg.sv
// Testbench for demux4_reg: directed steps from the test plan followed by
// randomized traffic, all checked against a lane-array reference model.
module tb_demux4_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_data;
    logic [1:0]  in_select;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [2:0]  occupancy;
    logic        bcast;

    int checks = 0;
    int errors = 0;

    // Reference model: one valid flag and one data word per lane.
    logic       m_valid [4];
    logic [3:0] m_data  [4];

    demux4_reg #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_select (in_select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef DEMUX4_BROADCAST_EN
        ,
        .bcast     (bcast)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = m_valid[n];
        return v;
    endfunction

    function automatic logic [15:0] m_data_vec();
        logic [15:0] d;
        for (int n = 0; n < 4; n++) d[n*4 +: 4] = m_data[n];
        return d;
    endfunction

    function automatic logic [15:0] m_count();
        int c = 0;
        for (int n = 0; n < 4; n++) c += m_valid[n] ? 1 : 0;
        return 16'(c);
    endfunction

    // One clock cycle: drive inputs, check in_ready, advance the model, then
    // check registered outputs one time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic [1:0] s,
                        input logic [3:0] d, input logic [3:0] ordy, input logic b);
        logic free [4];
        logic exp_rdy;
        logic bc;
        @(negedge clk);
        rst = r; in_valid = v; in_select = s; in_data = d; out_ready = ordy; bcast = b;
`ifdef DEMUX4_BROADCAST_EN
        bc = b;
`else
        bc = 1'b0;
`endif
        #1;
        for (int n = 0; n < 4; n++) free[n] = !m_valid[n] || ordy[n];
        if (bc) exp_rdy = free[0] && free[1] && free[2] && free[3];
        else    exp_rdy = free[s];
        chk("in_ready", {15'd0, in_ready}, {15'd0, exp_rdy});
        if (r) begin
            for (int n = 0; n < 4; n++) begin
                m_valid[n] = 1'b0;
                m_data[n]  = 4'h0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (v && exp_rdy && (bc || s == 2'(n))) begin
                    m_valid[n] = 1'b1;
                    m_data[n]  = d;
                end else if (m_valid[n] && ordy[n]) begin
                    m_valid[n] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {12'd0, out_valid}, {12'd0, m_valid_vec()});
        chk("out_data",  out_data, m_data_vec());
        chk("occupancy", {13'd0, occupancy}, m_count());
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            m_valid[n] = 1'b0;
            m_data[n]  = 4'h0;
        end
        rst = 1'b1; in_valid = 1'b0; in_select = 2'd0; in_data = 4'h0;
        out_ready = 4'h0; bcast = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with an offer present: nothing is loaded.
        step(1'b1, 1'b1, 2'd2, 4'hA, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd2, 4'hA, 4'h0, 1'b0);
        chk("reset_valid", {12'd0, out_valid}, 16'h0000);
        chk("reset_occ", {13'd0, occupancy}, 16'h0000);
        chk("reset_data", out_data, 16'h0000);

        // Unicast fill of lane 2, then a blocked offer and an offer to lane 0.
        step(1'b0, 1'b1, 2'd2, 4'hA, 4'h0, 1'b0);
        chk("fill_valid", {12'd0, out_valid}, 16'h0004);
        chk("fill_lane2", {12'd0, out_data[11:8]}, 16'h000A);
        chk("fill_occ", {13'd0, occupancy}, 16'h0001);
        step(1'b0, 1'b1, 2'd2, 4'hB, 4'h0, 1'b0);
        chk("fill_lane2_held", {12'd0, out_data[11:8]}, 16'h000A);
        step(1'b0, 1'b1, 2'd0, 4'h3, 4'h0, 1'b0);
        chk("fill_two_lanes", {12'd0, out_valid}, 16'h0005);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0);

        // Pass-through: one word per cycle with every consumer ready.
        step(1'b0, 1'b1, 2'd0, 4'h1, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'd1, 4'h2, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'h3, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'd3, 4'h4, 4'hF, 1'b0);
        chk("pass_occ", {13'd0, occupancy}, 16'h0001);
        chk("pass_lane3", {12'd0, out_data[15:12]}, 16'h0004);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0);

        // Drain and refill of lane 1 on the same edge.
        step(1'b0, 1'b1, 2'd1, 4'h5, 4'h0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 4'h6, 4'b0010, 1'b0);
        chk("refill_valid", {12'd0, out_valid}, 16'h0002);
        chk("refill_lane1", {12'd0, out_data[7:4]}, 16'h0006);

        // Mid-operation reset coincident with a transfer to lane 1.
        step(1'b0, 1'b1, 2'd0, 4'h7, 4'b0010, 1'b0);
        step(1'b0, 1'b1, 2'd3, 4'h8, 4'h0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 4'h9, 4'h0, 1'b0);
        chk("midrst_valid", {12'd0, out_valid}, 16'h0000);
        chk("midrst_occ", {13'd0, occupancy}, 16'h0000);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);

`ifdef DEMUX4_BROADCAST_EN
        // Broadcast into empty lanes, then blocked by a stalled lane 2.
        step(1'b0, 1'b1, 2'd1, 4'hF, 4'h0, 1'b1);
        chk("bcast_valid", {12'd0, out_valid}, 16'h000F);
        chk("bcast_occ", {13'd0, occupancy}, 16'h0004);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
        step(1'b0, 1'b1, 2'd2, 4'h2, 4'h0, 1'b0);
        step(1'b0, 1'b1, 2'd0, 4'hC, 4'h0, 1'b1);
        chk("bcast_block_valid", {12'd0, out_valid}, 16'h0004);
        step(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 1'($urandom),
                 2'($urandom),
                 4'($urandom),
                 4'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
